// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Entry layout places the instruction above its byte PC.
package fetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RSP
    } req_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with registered storage and a combinational head.
// Clear empties the queue in one cycle and overrides push/pop.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      cnt;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (cnt != '0);
    assign do_push = push && ((cnt != FULL_CNT) || do_pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                cnt <= cnt + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                cnt <= cnt - (AW+1)'(1);
            end
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = cnt;
    assign empty = (cnt == '0);
    assign full  = (cnt == FULL_CNT);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch: sequential PC generation, one in-flight memory
// request, and a small buffer of {inst, pc} entries toward decode.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [29:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        empty,
    output logic        full
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [31:0] PC_STEP  = 32'(WORD_BYTES);
    localparam logic [31:0] PC_ALIGN = ~32'(WORD_BYTES - 1);

    req_state_t   state;
    req_state_t   state_nxt;
    logic [31:0]  fetch_pc;
    logic         drop;
    logic         outstanding;
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic         can_issue;
    logic         grant;
    logic         push;
    logic         pop;
    fetch_entry_t entry_in;
    fetch_entry_t head;

    assign outstanding = (state == WAIT_RSP);
    assign inflight    = {{(CW-1){1'b0}}, outstanding};

    // Slot reservation: never ask for more than the buffer can absorb.
    assign can_issue = reset && !halt && !redirect && !outstanding
                    && ((count + inflight) < CW'(DEPTH));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, WAIT_GNT: begin
                if (can_issue && imem_gnt) begin
                    state_nxt = WAIT_RSP;
                end else if (can_issue) begin
                    state_nxt = WAIT_GNT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT_RSP: begin
                if (imem_rvalid) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_req = 1'b0;
        unique case (state)
            IDLE, WAIT_GNT: imem_req = can_issue;
            default:        imem_req = 1'b0;
        endcase
    end

    assign imem_addr = fetch_pc[31:2];
    assign grant     = imem_req && imem_gnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
            drop     <= 1'b0;
        end else begin
            if (redirect) begin
                fetch_pc <= redirect_pc & PC_ALIGN;
            end else if (grant) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (outstanding && imem_rvalid) begin
                drop <= 1'b0;
            end else if (redirect && outstanding) begin
                drop <= 1'b1;
            end
        end
    end

    // Only one request is ever in flight, so its PC is one step behind.
    assign entry_in.inst = imem_rdata;
    assign entry_in.pc   = fetch_pc - PC_STEP;

    assign push = outstanding && imem_rvalid && !drop && !redirect;
    assign pop  = inst_valid && inst_ready && !redirect;

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (redirect),
        .din   (entry_in),
        .dout  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    assign inst_valid = !empty;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized scoreboard bench for fetch_queue with a PC-stream reference
// model and a single-outstanding instruction memory model.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'hFFFF_FFF8;
    localparam int          NCYC  = 3000;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [29:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        empty;
    logic        full;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clock       (clock),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .empty       (empty),
        .full        (full)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int n_pops = 0;

    // Expected {inst, pc} entries currently buffered toward decode.
    logic [63:0] q[$];

    logic [31:0] m_pc;
    logic [31:0] m_rpc;
    logic        m_out;
    logic        m_drop;

    logic        r_gnt, r_rv, r_redir;
    logic [31:0] r_rpc;

    logic        mem_pend;
    logic [29:0] mem_addr;
    int          mem_lat;
    int          rdy_bias;

    function automatic logic [31:0] memf(logic [31:0] pc);
        return {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc    = RPC;
        m_rpc   = '0;
        m_out   = 1'b0;
        m_drop  = 1'b0;
        r_gnt   = 1'b0;
        r_rv    = 1'b0;
        r_redir = 1'b0;
        r_rpc   = '0;
    endtask

    task automatic apply();
        if (r_rv && m_out) begin
            if (!m_drop && !r_redir) q.push_back({memf(m_rpc), m_rpc});
            m_out  = 1'b0;
            m_drop = 1'b0;
        end else if (r_redir && m_out) begin
            m_drop = 1'b1;
        end
        if (r_redir) begin
            q.delete();
            m_pc = r_rpc & 32'hFFFF_FFFC;
        end
        if (r_gnt) begin
            m_rpc = m_pc;
            m_pc  = m_pc + 32'd4;
            m_out = 1'b1;
        end
    endtask

    task automatic drive(int cyc);
        int ph;
        ph = cyc % 700;
        if ($urandom_range(0, 15) == 0) halt = ~halt;
        redirect = ($urandom_range(0, 23) == 0);
        if ($urandom_range(0, 3) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
        else redirect_pc = $urandom;
        if (cyc % 100 == 0) rdy_bias = $urandom_range(0, 10);
        inst_ready = ($urandom_range(0, 9) < rdy_bias);
        if (ph >= 680) begin
            inst_ready = 1'b0;
            halt       = 1'b0;
            redirect   = 1'b0;
        end
        imem_gnt    = !mem_pend && ($urandom_range(0, 3) != 0);
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_pend) begin
            mem_lat--;
            if (mem_lat == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memf({mem_addr, 2'b00});
                mem_pend    = 1'b0;
            end
        end else if ($urandom_range(0, 15) == 0) begin
            imem_rvalid = 1'b1;
            imem_gnt    = 1'b0;
        end
    endtask

    task automatic sample();
        logic exp_req;
        exp_req = !halt && !redirect && !m_out && (q.size() < DEPTH);
        chk("imem_req", imem_req, exp_req);
        if (imem_req && exp_req) chk("imem_addr", imem_addr, m_pc[31:2]);
        r_gnt   = imem_req && imem_gnt;
        r_rv    = imem_rvalid;
        r_redir = redirect;
        r_rpc   = redirect_pc;
        if (imem_req && imem_gnt) begin
            mem_pend = 1'b1;
            mem_addr = imem_addr;
            mem_lat  = $urandom_range(1, 3);
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", inst_valid, 1'b0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_flags", {empty, full}, 2'b10);
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                chk("status", {inst_valid, empty, full},
                    {q.size() != 0, q.size() == 0, q.size() == DEPTH});
                if (inst_valid && inst_ready && !redirect && q.size() != 0) begin
                    chk("entry", {inst, inst_pc}, q.pop_front());
                    n_pops++;
                end
            end
        end
    end

    initial begin
        reset       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        halt        = 1'b0;
        mem_pend    = 1'b0;
        mem_addr    = '0;
        mem_lat     = 0;
        rdy_bias    = 8;
        model_reset();
        #2;
        check_reset_outputs();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        for (int cyc = 1; cyc < NCYC; cyc++) begin
            @(posedge clock);
            apply();
            #1 drive(cyc);
            #1 sample();
            if (cyc % 700 == 699) begin
                #1 reset = 1'b0;
                #1 check_reset_outputs();
                model_reset();
                redirect    = 1'b0;
                halt        = 1'b0;
                imem_gnt    = 1'b0;
                imem_rvalid = 1'b0;
                repeat (2) @(posedge clock);
                #1 reset = 1'b1;
            end
        end
        @(posedge clock);
        #2;
        n_cmp++;
        if (n_pops < 50) begin
            n_bad++;
            $display("FAIL throughput: got %0d pops expected at least 50", n_pops);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
